// File: rtl/msrv32_pkg.sv
// Shared constants and helpers for the msrv32 writeback path.
// Holds the register-file geometry and the arbiter pointer width.
package msrv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // A single requester still needs a one-bit pointer register.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msrv32_rr_arbiter.sv
// Rotating-priority one-hot arbiter with its own priority pointer.
// The scan starts at the pointer; RrEn=0 pins the pointer at index 0.
module msrv32_rr_arbiter
  import msrv32_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter bit          RrEn   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = ptr_width(NumReq);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW:0]   pos;
  logic            found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // pos = (ptr + k) mod NumReq, kept one bit wider to avoid overflow
      pos = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (pos >= (PtrW + 1)'(NumReq)) begin
        pos = pos - (PtrW + 1)'(NumReq);
      end
      if (en_i && !found && req_i[pos[PtrW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[pos[PtrW-1:0]]   = 1'b1;
        if (RrEn) begin
          if (pos == (PtrW + 1)'(NumReq - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = pos[PtrW-1:0] + PtrW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/msrv32_wb_arbiter.sv
// Writeback arbiter sharing the integer register file write port.
// Registers the winner into a one-entry stage and bypasses it to both read ports.
module msrv32_wb_arbiter
  import msrv32_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic                          ms_riscv32_mp_clk_in,
  input  logic                          ms_riscv32_mp_rst_in,
  input  logic                          hold_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd_addr_in,
  input  logic [XLEN*NUM_REQ-1:0]       req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          wr_en_out,
  output logic [REG_ADDR_W-1:0]         rd_addr_out,
  output logic [XLEN-1:0]               rd_out,
  input  logic [REG_ADDR_W-1:0]         rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0]         rs_2_addr_in,
  output logic                          rs_1_fwd_out,
  output logic [XLEN-1:0]               rs_1_fwd_data_out,
  output logic                          rs_2_fwd_out,
  output logic [XLEN-1:0]               rs_2_fwd_data_out
);

  logic [NUM_REQ-1:0]    gnt;
  logic                  arb_en;
  logic                  any_gnt;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_q, rd_d;

  // Reset gates the grant combinationally so ready is 0 while reset is held.
  assign arb_en = ~hold_in & ms_riscv32_mp_rst_in;

  msrv32_rr_arbiter #(
    .NumReq (NUM_REQ),
    .RrEn   (RR_EN)
  ) u_rr_arbiter (
    .clk_i  (ms_riscv32_mp_clk_in),
    .rst_ni (ms_riscv32_mp_rst_in),
    .en_i   (arb_en),
    .req_i  (req_valid_in),
    .gnt_o  (gnt)
  );

  assign req_ready_out = gnt;
  assign any_gnt       = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_rd_addr_in[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data_in[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes retire normally but never reach the register file.
  always_comb begin
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    if (any_gnt) begin
      wr_en_d   = (sel_addr != ZERO_REG);
      rd_addr_d = sel_addr;
      rd_d      = sel_data;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign rd_addr_out = rd_addr_q;
  assign rd_out      = rd_q;

  assign rs_1_fwd_out      = wr_en_q & (rd_addr_q != ZERO_REG) & (rs_1_addr_in == rd_addr_q);
  assign rs_2_fwd_out      = wr_en_q & (rd_addr_q != ZERO_REG) & (rs_2_addr_in == rd_addr_q);
  assign rs_1_fwd_data_out = rs_1_fwd_out ? rd_q : '0;
  assign rs_2_fwd_data_out = rs_2_fwd_out ? rd_q : '0;

endmodule
